// File: rtl/sram_adaptor.sv
// ============================================================================
// Module  : sram_adaptor
// Brief   : Request/response controller for a 256Kx16 asynchronous SRAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_adaptor #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        iClock,
  input  logic        iRst,
  input  logic        iAdaptor_en,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [17:0] iAddr,
  input  logic [15:0] iWdata,
  input  logic [1:0]  iBe,
  output logic        oReady,
  output logic        oRvalid,
  output logic [15:0] oRdata,
  output logic [17:0] oSRAM_ADDR,
  inout  wire  [15:0] ioSRAM_DQ,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_WE_N,
  output logic        oSRAM_UB_N,
  output logic        oSRAM_LB_N
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACCESS  = 2'd1;
  localparam logic [1:0] c_RECOVER = 2'd2;
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]  r_state, w_stateNext;
  logic [3:0]  r_waitCnt, w_waitCnt;
  logic        r_we, w_we;
  logic [1:0]  r_be, w_be;
  logic        r_ready, w_ready;
  logic        r_rvalid, w_rvalid;
  logic [15:0] r_rdata, w_rdata;
  logic [17:0] r_addr, w_addr;
  logic        r_ceN, w_ceN;
  logic        r_oeN, w_oeN;
  logic        r_weN, w_weN;
  logic        r_ubN, w_ubN;
  logic        r_lbN, w_lbN;
  logic        r_dqOe, w_dqOe;
  logic [15:0] r_dqOut, w_dqOut;
  logic        w_accept;
  logic        w_cntDone;

  assign w_accept  = (r_state == c_IDLE) && r_ready && iReq;
  assign w_cntDone = (r_waitCnt == 4'd0);

  always_ff @(posedge iClock) begin
    if (iRst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_IDLE:    if (w_accept) w_stateNext = c_ACCESS;
      c_ACCESS:  if (w_cntDone) w_stateNext = c_RECOVER;
      c_RECOVER: w_stateNext = c_IDLE;
      default:   w_stateNext = c_IDLE;
    endcase
  end

  // Next values of every registered output; the strobes change on the same
  // edge as the state so they are clean for the whole cycle they cover.
  always_comb begin
    w_waitCnt = r_waitCnt;
    w_we      = r_we;
    w_be      = r_be;
    w_ready   = 1'b0;
    w_rvalid  = 1'b0;
    w_rdata   = r_rdata;
    w_addr    = r_addr;
    w_ceN     = 1'b1;
    w_oeN     = 1'b1;
    w_weN     = 1'b1;
    w_ubN     = 1'b1;
    w_lbN     = 1'b1;
    w_dqOe    = 1'b0;
    w_dqOut   = r_dqOut;
    case (r_state)
      c_IDLE: begin
        w_ready = iAdaptor_en;
        if (w_accept) begin
          w_ready   = 1'b0;
          w_we      = iWe;
          w_be      = iBe;
          w_addr    = iAddr;
          w_waitCnt = c_WAIT_LOAD;
          w_ceN     = 1'b0;
          w_oeN     = iWe;
          w_weN     = ~iWe;
          w_ubN     = ~iBe[1];
          w_lbN     = ~iBe[0];
          w_dqOe    = iWe;
          w_dqOut   = iWdata;
        end
      end
      c_ACCESS: begin
        w_dqOe = r_we;
        if (w_cntDone) begin
          if (!r_we) begin
            w_rvalid = 1'b1;
            w_rdata  = {(r_be[1] ? ioSRAM_DQ[15:8] : 8'h00),
                        (r_be[0] ? ioSRAM_DQ[7:0]  : 8'h00)};
          end
        end else begin
          w_waitCnt = r_waitCnt - 4'd1;
          w_ceN     = r_ceN;
          w_oeN     = r_oeN;
          w_weN     = r_weN;
          w_ubN     = r_ubN;
          w_lbN     = r_lbN;
        end
      end
      c_RECOVER: begin
        w_ready = iAdaptor_en;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iRst) begin
      r_waitCnt <= 4'd0;
      r_we      <= 1'b0;
      r_be      <= 2'b00;
      r_ready   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 16'h0000;
      r_addr    <= 18'h00000;
      r_ceN     <= 1'b1;
      r_oeN     <= 1'b1;
      r_weN     <= 1'b1;
      r_ubN     <= 1'b1;
      r_lbN     <= 1'b1;
      r_dqOe    <= 1'b0;
      r_dqOut   <= 16'h0000;
    end else begin
      r_waitCnt <= w_waitCnt;
      r_we      <= w_we;
      r_be      <= w_be;
      r_ready   <= w_ready;
      r_rvalid  <= w_rvalid;
      r_rdata   <= w_rdata;
      r_addr    <= w_addr;
      r_ceN     <= w_ceN;
      r_oeN     <= w_oeN;
      r_weN     <= w_weN;
      r_ubN     <= w_ubN;
      r_lbN     <= w_lbN;
      r_dqOe    <= w_dqOe;
      r_dqOut   <= w_dqOut;
    end
  end

  assign oReady     = r_ready;
  assign oRvalid    = r_rvalid;
  assign oRdata     = r_rdata;
  assign oSRAM_ADDR = r_addr;
  assign oSRAM_CE_N = r_ceN;
  assign oSRAM_OE_N = r_oeN;
  assign oSRAM_WE_N = r_weN;
  assign oSRAM_UB_N = r_ubN;
  assign oSRAM_LB_N = r_lbN;
  assign ioSRAM_DQ  = r_dqOe ? r_dqOut : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_sram_adaptor.sv
// ============================================================================
// Module  : tb_sram_adaptor
// Brief   : Directed + random bench for sram_adaptor (WAIT_CYCLES 1 and 3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_adaptor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        req1 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;

  logic        ready1, rvalid1, ce1, oe1, wen1, ub1, lb1;
  logic [15:0] rdata1;
  logic [17:0] sa1;
  wire  [15:0] dq1;
  logic        ready3, rvalid3, ce3, oe3, wen3, ub3, lb3;
  logic [15:0] rdata3;
  logic [17:0] sa3;
  wire  [15:0] dq3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastAccept = 0;
  int lastRecover = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  sram_adaptor #(.WAIT_CYCLES(1)) dut1 (
    .iClock(clk), .iRst(rst), .iAdaptor_en(en), .iReq(req1), .iWe(we),
    .iAddr(addr), .iWdata(wdata), .iBe(be), .oReady(ready1), .oRvalid(rvalid1),
    .oRdata(rdata1), .oSRAM_ADDR(sa1), .ioSRAM_DQ(dq1), .oSRAM_CE_N(ce1),
    .oSRAM_OE_N(oe1), .oSRAM_WE_N(wen1), .oSRAM_UB_N(ub1), .oSRAM_LB_N(lb1)
  );

  sram_adaptor #(.WAIT_CYCLES(3)) dut3 (
    .iClock(clk), .iRst(rst), .iAdaptor_en(en), .iReq(req3), .iWe(we),
    .iAddr(addr), .iWdata(wdata), .iBe(be), .oReady(ready3), .oRvalid(rvalid3),
    .oRdata(rdata3), .oSRAM_ADDR(sa3), .ioSRAM_DQ(dq3), .oSRAM_CE_N(ce3),
    .oSRAM_OE_N(oe3), .oSRAM_WE_N(wen3), .oSRAM_UB_N(ub3), .oSRAM_LB_N(lb3)
  );

  // Asynchronous SRAM models: drive on CE&OE with WE high, store bytes while WE low.
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem3 [0:262143];
  assign dq1 = (!ce1 && !oe1 && wen1) ? mem1[sa1] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && wen3) ? mem3[sa3] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce1 && !wen1) begin
      if (!ub1) mem1[sa1][15:8] <= dq1[15:8];
      if (!lb1) mem1[sa1][7:0]  <= dq1[7:0];
    end
    if (!ce3 && !wen3) begin
      if (!ub3) mem3[sa3][15:8] <= dq3[15:8];
      if (!lb3) mem3[sa3][7:0]  <= dq3[7:0];
    end
  end

  wire        sReady  = sel ? ready3 : ready1;
  wire        sRvalid = sel ? rvalid3 : rvalid1;
  wire [15:0] sRdata  = sel ? rdata3 : rdata1;
  wire [17:0] sAddr   = sel ? sa3 : sa1;
  wire [15:0] sDq     = sel ? dq3 : dq1;
  wire [4:0]  sStrb   = sel ? {ce3, oe3, wen3, ub3, lb3} : {ce1, oe1, wen1, ub1, lb1};

  // Reference memory contents as the requester expects them to be.
  logic [15:0] ref1 [bit [17:0]];
  logic [15:0] ref3 [bit [17:0]];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] refRead(input logic [17:0] a);
    if (sel) return ref3.exists(a) ? ref3[a] : 16'h0000;
    return ref1.exists(a) ? ref1[a] : 16'h0000;
  endfunction

  task automatic refWrite(input logic [17:0] a, input logic [15:0] d, input logic [1:0] b);
    logic [15:0] cur;
    cur = refRead(a);
    if (b[1]) cur[15:8] = d[15:8];
    if (b[0]) cur[7:0]  = d[7:0];
    if (sel) ref3[a] = cur;
    else     ref1[a] = cur;
  endtask

  // One complete transaction on the selected adaptor, checked cycle by cycle
  // against the timeline: ACCESS 1..W+1, RECOVER W+2, ready again W+3.
  task automatic doTxn(input bit isWr, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] b, input bit dropEn);
    int w;
    int i;
    logic [15:0] cur;
    logic [15:0] expR;
    w = sel ? 3 : 1;
    i = 0;
    while (sReady !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk("ready_before_req", sReady, 1);
    we = isWr; addr = a; wdata = d; be = b;
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    tick();
    lastAccept = cyc - 1;
    if (dropEn) en = 1'b0;
    else begin req1 = 1'b0; req3 = 1'b0; end
    we = 1'($urandom); addr = 18'($urandom); wdata = 16'($urandom); be = 2'($urandom);
    cur  = refRead(a);
    expR = {(b[1] ? cur[15:8] : 8'h00), (b[0] ? cur[7:0] : 8'h00)};
    for (int k = 1; k <= w + 1; k++) begin
      chk("access_strobes", sStrb, {1'b0, isWr, !isWr, ~b});
      chk("access_addr", sAddr, a);
      chk("access_ready_rvalid", {sReady, sRvalid}, 2'b00);
      if (isWr) chk("access_dq", sDq, d);
      tick();
    end
    lastRecover = cyc;
    chk("recover_strobes", sStrb, 5'h1f);
    chk("recover_ready_rvalid", {sReady, sRvalid}, {1'b0, !isWr});
    if (isWr) chk("recover_dq_hold", sDq, d);
    else      chk("read_data", sRdata, expR);
    tick();
    chk("after_ready", sReady, en);
    chk("after_rvalid", sRvalid, 0);
    if (isWr) refWrite(a, d, b);
  endtask

  logic [17:0] pool [8];

  initial begin
    int acc0;
    int rdAcc;
    // Reset defaults on both instances
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_strobes1", {ce1, oe1, wen1, ub1, lb1}, 5'h1f);
      chk("rst_strobes3", {ce3, oe3, wen3, ub3, lb3}, 5'h1f);
      chk("rst_ready_rvalid", {ready1, rvalid1, ready3, rvalid3}, 4'h0);
      chk("rst_rdata_addr", {rdata1, sa1}, 34'h0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_rst", {ready1, ready3}, 2'b11);

    // Default timing: write, overwrite, masked read
    sel = 1'b0;
    doTxn(1'b1, 18'h00123, 16'hA55A, 2'b11, 1'b0);
    chk("mem_after_write", mem1[18'h00123], 16'hA55A);
    doTxn(1'b1, 18'h00123, 16'hBEEF, 2'b11, 1'b0);
    doTxn(1'b0, 18'h00123, 16'h0000, 2'b10, 1'b0);
    chk("read_masked_value", rdata1, 16'hBE00);
    tick(); tick();
    chk("rdata_held", rdata1, 16'hBE00);
    doTxn(1'b0, 18'h00123, 16'h0000, 2'b00, 1'b0);
    chk("read_be00", rdata1, 16'h0000);

    // WAIT_CYCLES=3 back-to-back write then read
    sel = 1'b1;
    doTxn(1'b1, 18'h3FFFF, 16'h1234, 2'b11, 1'b0);
    acc0 = lastAccept;
    doTxn(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b0);
    rdAcc = lastAccept;
    chk("b2b_read_accept", rdAcc - acc0, 6);
    chk("b2b_rvalid_cycle", lastRecover - acc0, 11);
    chk("b2b_rdata", rdata3, 16'h1234);

    // Enable dropped during ACCESS cycle 1 of a write, request held high
    sel = 1'b0;
    doTxn(1'b1, 18'h00055, 16'h7E81, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("en_low_no_accept", {ready1, ce1}, 2'b01);
      tick();
    end
    chk("en_drop_write_landed", mem1[18'h00055][7:0], 8'h81);
    req1 = 1'b0;
    en = 1'b1;
    tick();
    chk("ready_after_en", ready1, 1);

    // Reset during ACCESS cycle 1 of a read
    we = 1'b0; addr = 18'h00123; be = 2'b11; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk("rstmid_access", {ce1, oe1, wen1, ub1, lb1}, 5'b00100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_strobes", {ce1, oe1, wen1, ub1, lb1}, 5'h1f);
    chk("rstmid_state", {ready1, rvalid1, rdata1}, 18'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstmid_no_rvalid", {rvalid1, rdata1}, 17'h0);
    end

    // Random traffic against the reference memory
    for (int i = 0; i < 8; i++) begin
      pool[i] = 18'($urandom);
      doTxn(1'b1, pool[i], 16'($urandom), 2'b11, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      doTxn(1'($urandom), pool[$urandom_range(7, 0)], 16'($urandom), 2'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
